vga_sync_decoder: RTL and testbench

- Receive side of the VGA timing interface: samples incoming active-low h_sync/v_sync (one pixel per clk) and reconstructs the pixel coordinate (x_loc, y_loc) and video_on.
- Lock FSM checks every sampled sync level against the level predicted from the recovered counters and reports mismatches.
- Sits behind an external/looped-back 640x480 sync source.
- Feeds capture, overlay and timing-checker logic.

---
 rtl/vga_timing_pkg.sv | 44 ++++
 rtl/sync_edge_det.sv | 34 +++
 rtl/vga_sync_decoder.sv | 187 ++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared timing definitions for the VGA sync generator and sync decoder.
//  - Default 640x480 timing (display, porches, retrace) and derived values:
//    last count of a line/frame (HMAX/VMAX) and sync pulse start/end counts.
//  - Lock FSM state type used by the decoder.
//  - in_window helper: true while a counter is inside a [lo, hi) window.
// All counters are 10 bits wide, so HMAX and VMAX must stay below 1024.

package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_HD = 640;
    localparam int DEF_HF = 16;
    localparam int DEF_HB = 48;
    localparam int DEF_HR = 96;
    localparam int DEF_VD = 480;
    localparam int DEF_VF = 10;
    localparam int DEF_VB = 33;
    localparam int DEF_VR = 2;
    localparam int DEF_LOCK_FRAMES = 2;

    localparam int DEF_HMAX = DEF_HD + DEF_HF + DEF_HB + DEF_HR - 1;
    localparam int DEF_VMAX = DEF_VD + DEF_VF + DEF_VB + DEF_VR - 1;

    // Sync pulses start right after the front porch and last for the retrace width
    localparam int DEF_H_SYNC_START = DEF_HD + DEF_HF;
    localparam int DEF_H_SYNC_END   = DEF_HD + DEF_HF + DEF_HR;
    localparam int DEF_V_SYNC_START = DEF_VD + DEF_VF;
    localparam int DEF_V_SYNC_END   = DEF_VD + DEF_VF + DEF_VR;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_t;

    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det
// Two-stage input register for one active-low sync line plus a falling-edge
// pulse. Both stages reset high (sync inactive) so no edge is reported out
// of reset.
// Ports:
//   clk      in   pixel clock
//   reset_n  in   asynchronous active-low reset
//   sync_in  in   raw incoming sync level
//   sync_q2  out  sync level delayed by two clocks
//   fall     out  high for one cycle when the first-stage level has just dropped

module sync_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic sync_in,
    output logic sync_q2,
    output logic fall
);

    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q  <= sync_in;
            sync_q2 <= sync_q;
        end
    end

    assign fall = ~sync_q & sync_q2;

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
// Receive side of the VGA timing interface. Samples active-low h/v sync,
// rebuilds the pixel coordinate two clocks behind the source and runs a
// lock FSM that compares every sampled sync level with the level predicted
// from the recovered counters.
// Ports:
//   clk          in   pixel clock
//   reset_n      in   asynchronous active-low reset
//   h_sync_in    in   incoming horizontal sync, active low
//   v_sync_in    in   incoming vertical sync, active low
//   x_loc        out  recovered horizontal count 0..HMAX
//   y_loc        out  recovered vertical count 0..VMAX
//   video_on     out  locked and inside the display area
//   locked       out  FSM is in LOCKED
//   frame_start  out  one-cycle pulse at (0,0) while locked
//   sync_err     out  one-cycle pulse on a sync mismatch in ACQUIRE/LOCKED
//   err_count    out  16-bit saturating count of sync_err pulses
//                     (present only when VGA_SYNC_DEC_ERRCNT_EN is defined)
// Optional feature macro: VGA_SYNC_DEC_ERRCNT_EN

module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int HD          = DEF_HD,
    parameter int HF          = DEF_HF,
    parameter int HB          = DEF_HB,
    parameter int HR          = DEF_HR,
    parameter int VD          = DEF_VD,
    parameter int VF          = DEF_VF,
    parameter int VB          = DEF_VB,
    parameter int VR          = DEF_VR,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             h_sync_in,
    input  logic             v_sync_in,
    output logic [CNT_W-1:0] x_loc,
    output logic [CNT_W-1:0] y_loc,
    output logic             video_on,
    output logic             locked,
    output logic             frame_start,
    output logic             sync_err
`ifdef VGA_SYNC_DEC_ERRCNT_EN
    ,
    output logic [15:0]      err_count
`endif
);

    // The parameter sums must keep HMAX and VMAX below 1024; there is no
    // other wrap besides the end-of-line and end-of-frame returns to zero.
    localparam logic [CNT_W-1:0] HMAX         = CNT_W'(HD + HF + HB + HR - 1);
    localparam logic [CNT_W-1:0] VMAX         = CNT_W'(VD + VF + VB + VR - 1);
    localparam logic [CNT_W-1:0] HD_W         = CNT_W'(HD);
    localparam logic [CNT_W-1:0] VD_W         = CNT_W'(VD);
    localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(HD + HF);
    localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(HD + HF + HR);
    localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(VD + VF);
    localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(VD + VF + VR);
    localparam logic [7:0]       LOCK_CNT     = 8'(LOCK_FRAMES);

    logic             hs_q2, vs_q2;
    logic             hfall, vfall;
    logic [CNT_W-1:0] x_next, y_next;
    logic             exp_h, exp_v, mismatch;
    lock_state_t      state, state_next;
    logic [7:0]       frame_cnt, frame_cnt_next, frame_inc;
    logic             err_pulse;

    sync_edge_det u_h_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sync_in (h_sync_in),
        .sync_q2 (hs_q2),
        .fall    (hfall)
    );

    sync_edge_det u_v_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sync_in (v_sync_in),
        .sync_q2 (vs_q2),
        .fall    (vfall)
    );

    // A detected falling edge means the source is one count into its sync
    // pulse, so reloading with the sync start value lines the counter up with
    // the source two clocks back. The counters free-run in every state.
    always_comb begin
        x_next = x_loc + 10'd1;
        if (hfall) begin
            x_next = H_SYNC_START;
        end else if (x_loc == HMAX) begin
            x_next = '0;
        end

        y_next = y_loc;
        if (vfall) begin
            y_next = V_SYNC_START;
        end else if (x_loc == HMAX) begin
            y_next = (y_loc == VMAX) ? '0 : y_loc + 10'd1;
        end
    end

    // hs_q2/vs_q2 are aligned with x_loc/y_loc, so any difference from the
    // predicted level exposes short, long, missing or mistimed pulses.
    always_comb begin
        exp_h    = ~in_window(x_loc, H_SYNC_START, H_SYNC_END);
        exp_v    = ~in_window(y_loc, V_SYNC_START, V_SYNC_END);
        mismatch = (hs_q2 != exp_h) || (vs_q2 != exp_v);
    end

    // Lock FSM: the first vsync edge starts acquisition, LOCK_FRAMES further
    // clean frames lock. A mismatch takes priority over a vsync edge.
    // err_pulse is combinational so sync_err lines up with the offending
    // x_loc/y_loc.
    always_comb begin
        state_next     = state;
        frame_cnt_next = frame_cnt;
        frame_inc      = frame_cnt + 8'd1;
        err_pulse      = 1'b0;
        unique case (state)
            SEARCH: begin
                if (vfall) begin
                    state_next     = ACQUIRE;
                    frame_cnt_next = '0;
                end
            end
            ACQUIRE: begin
                if (mismatch) begin
                    state_next = SEARCH;
                    err_pulse  = 1'b1;
                end else if (vfall) begin
                    frame_cnt_next = frame_inc;
                    if (frame_inc == LOCK_CNT) begin
                        state_next = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (mismatch) begin
                    state_next = SEARCH;
                    err_pulse  = 1'b1;
                end
            end
            default: begin
                state_next = SEARCH;
            end
        endcase
    end

    // Status outputs are registered from the next-state values so they stay
    // aligned with the x_loc/y_loc being presented in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_loc       <= '0;
            y_loc       <= '0;
            state       <= SEARCH;
            frame_cnt   <= '0;
            locked      <= 1'b0;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            x_loc       <= x_next;
            y_loc       <= y_next;
            state       <= state_next;
            frame_cnt   <= frame_cnt_next;
            locked      <= (state_next == LOCKED);
            video_on    <= (state_next == LOCKED) && (x_next < HD_W) && (y_next < VD_W);
            frame_start <= (state_next == LOCKED) && (x_next == '0) && (y_next == '0);
        end
    end

    assign sync_err = err_pulse;

`ifdef VGA_SYNC_DEC_ERRCNT_EN
    // Saturating error tally; only reset clears it, so it survives relocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (err_pulse && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder
// Drives the decoder from a small behavioural sync source (scaled-down
// timing so several frames fit in a short run) and checks lock sequencing,
// coordinate recovery, error detection and asynchronous reset.

module tb_vga_sync_decoder;

    localparam int HD = 16;
    localparam int HF = 4;
    localparam int HB = 6;
    localparam int HR = 8;
    localparam int VD = 10;
    localparam int VF = 2;
    localparam int VB = 3;
    localparam int VR = 2;

    // Hand-summed timing for the scaled source
    localparam int HMAX   = 33;
    localparam int VMAX   = 16;
    localparam int HSS    = 20;
    localparam int HSE    = 28;
    localparam int VSS    = 12;
    localparam int VSE    = 14;
    localparam int FRAME  = 578;
    localparam int BUDGET = 5 * FRAME;

    logic       clk;
    logic       reset_n;
    logic       h_sync_in;
    logic       v_sync_in;
    logic [9:0] x_loc;
    logic [9:0] y_loc;
    logic       video_on;
    logic       locked;
    logic       frame_start;
    logic       sync_err;
`ifdef VGA_SYNC_DEC_ERRCNT_EN
    logic [15:0] err_count;
`endif

    int checks;
    int errors;
    int h_cur, v_cur, h_d1, v_d1, h_d2, v_d2;
    int stretch_req, suppress_req, suppress_active;

    typedef struct {
        int   h;
        int   v;
        int   exp_x;
        int   exp_y;
        int   exp_von;
        int   exp_fs;
    } vec_t;

    vec_t vecs[10];

    vga_sync_decoder #(
        .HD(HD), .HF(HF), .HB(HB), .HR(HR),
        .VD(VD), .VF(VF), .VB(VB), .VR(VR),
        .LOCK_FRAMES(2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .h_sync_in   (h_sync_in),
        .v_sync_in   (v_sync_in),
        .x_loc       (x_loc),
        .y_loc       (y_loc),
        .video_on    (video_on),
        .locked      (locked),
        .frame_start (frame_start),
        .sync_err    (sync_err)
`ifdef VGA_SYNC_DEC_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Computes the sync levels for the current source position, applying any
    // requested one-shot fault (stretched or suppressed h pulse).
    task automatic driveSync;
        logic hs;
        hs = !(h_cur >= HSS && h_cur < HSE);
        if (stretch_req != 0 && h_cur == HSE) begin
            hs          = 1'b0;
            stretch_req = 0;
        end
        if (suppress_req != 0 && h_cur == HSS) begin
            suppress_active = 1;
            suppress_req    = 0;
        end
        if (suppress_active != 0) begin
            if (h_cur >= HSS && h_cur < HSE) hs = 1'b1;
            else suppress_active = 0;
        end
        h_sync_in = hs;
        v_sync_in = !(v_cur >= VSS && v_cur < VSE);
    endtask

    task automatic startSource(input int h, input int v);
        h_cur = h;
        v_cur = v;
        h_d1  = -1;
        v_d1  = -1;
        h_d2  = -1;
        v_d2  = -1;
        driveSync();
    endtask

    // One clock: after the edge, h_d2/v_d2 hold the source position the DUT
    // should now be presenting on x_loc/y_loc.
    task automatic applyStimulus;
        @(posedge clk);
        #1;
        h_d2 = h_d1;
        v_d2 = v_d1;
        h_d1 = h_cur;
        v_d1 = v_cur;
        if (h_cur == HMAX) begin
            h_cur = 0;
            v_cur = (v_cur == VMAX) ? 0 : v_cur + 1;
        end else begin
            h_cur++;
        end
        driveSync();
    endtask

    task automatic releaseReset(input int h, input int v);
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        startSource(h, v);
    endtask

    // Runs until the third vsync falling edge seen by the DUT, then expects
    // locked one cycle later, with no early lock and no error after ACQUIRE.
    task automatic lockSequence(input string tag);
        int vf, n, early, acq_err, y_first;
        vf = 0; n = 0; early = 0; acq_err = 0; y_first = -1;
        while (vf < 3 && n < BUDGET) begin
            applyStimulus();
            n++;
            if (vf >= 1 && sync_err) acq_err++;
            if (vf == 1 && y_first < 0) y_first = int'(y_loc);
            if (locked) early = 1;
            if (h_d1 == 0 && v_d1 == VSS) vf++;
        end
        checkOutput({tag, " vfall count"}, vf, 3);
        checkOutput({tag, " y reload"}, y_first, VSS);
        checkOutput({tag, " early lock"}, early, 0);
        checkOutput({tag, " acquire sync_err"}, acq_err, 0);
        applyStimulus();
        checkOutput({tag, " locked"}, 32'(locked), 1);
    endtask

    task automatic waitSyncErr(input string tag, input int exp_x);
        int n, seen, err_x;
        n = 0; seen = 0; err_x = -1;
        while (seen == 0 && n < BUDGET) begin
            applyStimulus();
            n++;
            if (sync_err) begin
                seen  = 1;
                err_x = int'(x_loc);
            end
        end
        checkOutput({tag, " sync_err seen"}, seen, 1);
        checkOutput({tag, " sync_err x_loc"}, err_x, exp_x);
        applyStimulus();
        checkOutput({tag, " locked dropped"}, 32'(locked), 0);
        checkOutput({tag, " sync_err single"}, 32'(sync_err), 0);
    endtask

    task automatic waitPos(input string tag, input int h, input int v);
        int n;
        n = 0;
        while (!(h_d2 == h && v_d2 == v) && n < BUDGET) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, " reached"}, (h_d2 == h && v_d2 == v) ? 1 : 0, 1);
    endtask

    initial begin
        int fs, xbad, errs;
        checks = 0; errors = 0;
        stretch_req = 0; suppress_req = 0; suppress_active = 0;
        h_sync_in = 1'b1; v_sync_in = 1'b1; reset_n = 1'b1;
        h_cur = 0; v_cur = 0; h_d1 = -1; v_d1 = -1; h_d2 = -1; v_d2 = -1;

        vecs[0] = '{0,  0,  0,  0,  1, 1};
        vecs[1] = '{15, 0,  15, 0,  1, 0};
        vecs[2] = '{16, 0,  16, 0,  0, 0};
        vecs[3] = '{33, 0,  33, 0,  0, 0};
        vecs[4] = '{0,  1,  0,  1,  1, 0};
        vecs[5] = '{5,  9,  5,  9,  1, 0};
        vecs[6] = '{5,  10, 5,  10, 0, 0};
        vecs[7] = '{20, 12, 20, 12, 0, 0};
        vecs[8] = '{33, 16, 33, 16, 0, 0};
        vecs[9] = '{0,  0,  0,  0,  1, 1};

        #1 reset_n = 1'b0;
        #12;
        checkOutput("reset x_loc", 32'(x_loc), 0);
        checkOutput("reset y_loc", 32'(y_loc), 0);
        checkOutput("reset locked", 32'(locked), 0);
        checkOutput("reset video_on", 32'(video_on), 0);
        checkOutput("reset frame_start", 32'(frame_start), 0);
        checkOutput("reset sync_err", 32'(sync_err), 0);

        // Clean stream from (0,0)
        releaseReset(0, 0);
        lockSequence("clean");

        fs = 0; xbad = 0; errs = 0;
        for (int i = 0; i < FRAME; i++) begin
            applyStimulus();
            if (frame_start) fs++;
            if (32'(x_loc) != h_d2 || 32'(y_loc) != v_d2) xbad++;
            if (sync_err) errs++;
        end
        checkOutput("frame_start per frame", fs, 1);
        checkOutput("coord tracking errors", xbad, 0);
        checkOutput("frame sync_err", errs, 0);

        for (int i = 0; i < 10; i++) begin
            waitPos($sformatf("vec%0d", i), vecs[i].h, vecs[i].v);
            checkOutput($sformatf("vec%0d x_loc", i), 32'(x_loc), vecs[i].exp_x);
            checkOutput($sformatf("vec%0d y_loc", i), 32'(y_loc), vecs[i].exp_y);
            checkOutput($sformatf("vec%0d video_on", i), 32'(video_on), vecs[i].exp_von);
            checkOutput($sformatf("vec%0d frame_start", i), 32'(frame_start), vecs[i].exp_fs);
            checkOutput($sformatf("vec%0d locked", i), 32'(locked), 1);
        end

        // Stretched h pulse: error where the source should have gone high
        stretch_req = 1;
        waitSyncErr("stretch", HSE);
        lockSequence("stretch relock");

        // Missing h pulse: error at the expected start of the pulse
        suppress_req = 1;
        waitSyncErr("suppress", HSS);
        lockSequence("suppress relock");

`ifdef VGA_SYNC_DEC_ERRCNT_EN
        checkOutput("err_count after two errors", 32'(err_count), 2);
`endif

        // Asynchronous reset mid-line while locked and displaying
        waitPos("reset point", 5, 3);
        checkOutput("pre-reset video_on", 32'(video_on), 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async x_loc", 32'(x_loc), 0);
        checkOutput("async y_loc", 32'(y_loc), 0);
        checkOutput("async locked", 32'(locked), 0);
        checkOutput("async video_on", 32'(video_on), 0);
        checkOutput("async frame_start", 32'(frame_start), 0);
        checkOutput("async sync_err", 32'(sync_err), 0);
`ifdef VGA_SYNC_DEC_ERRCNT_EN
        checkOutput("async err_count", 32'(err_count), 0);
`endif
        releaseReset(0, 0);
        lockSequence("post-reset");

        // Source starting mid-frame
        #2 reset_n = 1'b0;
        releaseReset(12, 7);
        lockSequence("mid-frame");

`ifdef VGA_SYNC_DEC_ERRCNT_EN
        for (int i = 0; i < 3; i++) begin
            stretch_req = 1;
            waitSyncErr($sformatf("errcnt%0d", i), HSE);
            lockSequence($sformatf("errcnt%0d relock", i));
        end
        checkOutput("err_count three errors", 32'(err_count), 3);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("err_count cleared", 32'(err_count), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
